// File: rtl/if_fetch_buffer_pkg.sv
// if_fetch_buffer_pkg: fetch slot type and except-vector bit positions shared by the IF stage
package if_fetch_buffer_pkg;
  localparam int EXC_W = 19;
  localparam int IF_TLBRefill = 8;
  localparam int IF_TLBInvalid = 7;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [EXC_W-1:0] excepttype;
    logic filled;
  } fetch_slot_t;
endpackage

// File: rtl/if_fetch_buffer_if.sv
// if_fetch_buffer_if: PRE-IF request, I$ response, flush and ID handshake bundle
interface if_fetch_buffer_if;
  import if_fetch_buffer_pkg::*;
  logic preif_valid;
  logic preif_ready;
  logic [31:0] preif_pc;
  logic [EXC_W-1:0] preif_excepttype;
  logic preif_no_mem;
  logic icache_rvalid;
  logic [31:0] icache_rdata;
  logic flush;
  logic id_valid;
  logic id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [EXC_W-1:0] id_excepttype;
  modport master(
    output preif_valid, preif_pc, preif_excepttype, preif_no_mem, icache_rvalid, icache_rdata, flush, id_ready,
    input preif_ready, id_valid, id_pc, id_instr, id_excepttype
  );
  modport slave(
    input preif_valid, preif_pc, preif_excepttype, preif_no_mem, icache_rvalid, icache_rdata, flush, id_ready,
    output preif_ready, id_valid, id_pc, id_instr, id_excepttype
  );
endinterface

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: in-order IF slot buffer between PRE-IF/I$ and ID with flush-time response dropping
module if_fetch_buffer
  import if_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DROP_MAX = 3
) (
  input logic clk,
  input logic resetn,
  if_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DROP_MAX + 1);
  localparam int SW = AW + DW + 1;
  fetch_slot_t slots [DEPTH];
  fetch_slot_t head;
  logic [AW-1:0] wr, fill, rd;
  logic [AW:0] count, unfilled;
  logic [DW-1:0] drop_cnt;
  logic [SW-1:0] drop_sum;
  logic acc, pop, drop, fill_ok;
  always_comb begin
    head = slots[rd];
    bus.preif_ready = !bus.flush && count < (AW+1)'(DEPTH) && drop_cnt < DW'(DROP_MAX)
                      && (!bus.preif_no_mem || unfilled == '0);
    acc = bus.preif_valid && bus.preif_ready;
    bus.id_valid = count != '0 && head.filled;
    bus.id_pc = head.pc;
    bus.id_instr = head.instr;
    bus.id_excepttype = head.excepttype;
    pop = bus.id_valid && bus.id_ready;
    drop = bus.icache_rvalid && drop_cnt != '0;
    fill_ok = bus.icache_rvalid && drop_cnt == '0 && unfilled != '0;
    drop_sum = SW'(drop_cnt) + SW'(unfilled) - SW'(fill_ok) - SW'(drop);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      wr <= '0;
      fill <= '0;
      rd <= '0;
      count <= '0;
      unfilled <= '0;
      drop_cnt <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      wr <= '0;
      fill <= '0;
      rd <= '0;
      count <= '0;
      unfilled <= '0;
      drop_cnt <= DW'(drop_sum);
    end else begin
      if (fill_ok) begin
        slots[fill].instr <= bus.icache_rdata;
        slots[fill].filled <= 1'b1;
      end
      if (acc)
        slots[wr] <= '{pc: bus.preif_pc, instr: '0, excepttype: bus.preif_excepttype, filled: bus.preif_no_mem};
      wr <= wr + AW'(acc);
      fill <= fill + AW'(fill_ok || (acc && bus.preif_no_mem));
      rd <= rd + AW'(pop);
      count <= count + (AW+1)'(acc) - (AW+1)'(pop);
      unfilled <= unfilled + (AW+1)'(acc && !bus.preif_no_mem) - (AW+1)'(fill_ok);
      drop_cnt <= drop_cnt - DW'(drop);
    end
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!resetn)
    bus.icache_rvalid |-> (unfilled != '0 || drop_cnt != '0));
  a_drop_bound: assert property (@(posedge clk) disable iff (!resetn)
    bus.flush |-> drop_sum <= SW'(DROP_MAX));
endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: cycle-vector table plus scoreboard of slots delivered to ID
module tb_if_fetch_buffer;
  import if_fetch_buffer_pkg::*;
  typedef struct {
    logic rst, valid, no_mem, rvalid, flush, id_ready;
    logic [31:0] pc;
    logic [EXC_W-1:0] exc;
    logic exp_ready, exp_id_valid;
  } vec_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [EXC_W-1:0] exc;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] icq[$];
  vec_t tbl[$];
  logic held = 1'b0;
  logic [31:0] held_pc = '0;
  if_fetch_buffer_if bus();
  if_fetch_buffer dut(.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]};
  endfunction
  function automatic vec_t v(logic valid, logic [31:0] pc, logic no_mem, logic rvalid, logic flush,
                             logic id_ready, logic er, logic ev, logic [EXC_W-1:0] exc = '0, logic rst = 1'b0);
    vec_t r;
    r.rst = rst;
    r.valid = valid;
    r.pc = pc;
    r.no_mem = no_mem;
    r.rvalid = rvalid;
    r.flush = flush;
    r.id_ready = id_ready;
    r.exc = exc;
    r.exp_ready = er;
    r.exp_id_valid = ev;
    return r;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic step(vec_t x, string name);
    @(posedge clk);
    #1;
    resetn = !x.rst;
    bus.preif_valid = x.valid;
    bus.preif_pc = x.pc;
    bus.preif_excepttype = x.exc;
    bus.preif_no_mem = x.no_mem;
    bus.icache_rvalid = x.rvalid;
    bus.icache_rdata = (x.rvalid && icq.size() != 0) ? instr_of(icq.pop_front()) : 32'h0;
    bus.flush = x.flush;
    bus.id_ready = x.id_ready;
    @(negedge clk);
    check({name, " preif_ready"}, 32'(bus.preif_ready), 32'(x.exp_ready));
    check({name, " id_valid"}, 32'(bus.id_valid), 32'(x.exp_id_valid));
  endtask
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      icq.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold id_valid", 32'(bus.id_valid), 32'h1);
        check("hold id_pc", bus.id_pc, held_pc);
      end
      held = bus.id_valid && !bus.id_ready && !bus.flush;
      held_pc = bus.id_pc;
      if (bus.id_valid && bus.id_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected pop: got pc %h, expected no slot", bus.id_pc);
        end else begin
          e = sb.pop_front();
          check("id_pc", bus.id_pc, e.pc);
          check("id_instr", bus.id_instr, e.instr);
          check("id_excepttype", 32'(bus.id_excepttype), 32'(e.exc));
        end
      end
      if (bus.flush) sb.delete();
      if (bus.preif_valid && bus.preif_ready) begin
        sb.push_back({bus.preif_pc, bus.preif_no_mem ? 32'h0 : instr_of(bus.preif_pc), bus.preif_excepttype});
        if (!bus.preif_no_mem) icq.push_back(bus.preif_pc);
      end
    end
  end
  initial begin
    bus.preif_valid = 1'b0;
    bus.preif_pc = '0;
    bus.preif_excepttype = '0;
    bus.preif_no_mem = 1'b0;
    bus.icache_rvalid = 1'b0;
    bus.icache_rdata = '0;
    bus.flush = 1'b0;
    bus.id_ready = 1'b0;
    // back-to-back fetch
    tbl.push_back(v(1, 32'hBFC00000, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 32'hBFC00004, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 0));
    // backpressure
    tbl.push_back(v(1, 32'hBFC00008, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 32'hBFC0000C, 0, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 32'hBFC00010, 0, 1, 0, 0, 0, 1));
    tbl.push_back(v(1, 32'hBFC00010, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 32'hBFC00010, 0, 0, 0, 1, 0, 1));
    tbl.push_back(v(1, 32'hBFC00010, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 0));
    // flush with two outstanding
    tbl.push_back(v(1, 32'hBFC00100, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 32'hBFC00104, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 32'h80000180, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 0));
    // flush coinciding with a response
    tbl.push_back(v(1, 32'hBFC00200, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 32'hBFC00204, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(v(1, 32'hBFC00300, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 0));
    // TLB refill no_mem slot waits for earlier data
    tbl.push_back(v(1, 32'hBFC00400, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(1, 32'hBFC00408, 1, 0, 0, 1, 0, 0, 19'h00100));
    tbl.push_back(v(1, 32'hBFC00408, 1, 1, 0, 1, 0, 0, 19'h00100));
    tbl.push_back(v(1, 32'hBFC00408, 1, 0, 0, 1, 1, 1, 19'h00100));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 1, 1, 0));
    @(negedge clk);
    check("reset preif_ready", 32'(bus.preif_ready), 32'h1);
    check("reset id_valid", 32'(bus.id_valid), 32'h0);
    check("reset id_pc", bus.id_pc, 32'h0);
    check("reset id_instr", bus.id_instr, 32'h0);
    check("reset id_excepttype", 32'(bus.id_excepttype), 32'h0);
    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));
    // reset with count=2 and one response pending discard
    step(v(1, 32'hBFC00500, 0, 0, 0, 1, 1, 0), "rst_a");
    step(v(1, 32'hBFC00504, 0, 0, 0, 1, 1, 0), "rst_b");
    step(v(0, 32'h0, 0, 0, 1, 1, 0, 0), "rst_flush");
    step(v(1, 32'hBFC00600, 0, 1, 0, 1, 1, 0), "rst_c");
    step(v(1, 32'hBFC00604, 0, 0, 0, 1, 1, 0), "rst_d");
    step(v(0, 32'h0, 0, 0, 0, 1, 1, 0, '0, 1), "rst_assert");
    check("rst_assert id_pc", bus.id_pc, 32'h0);
    step(v(0, 32'h0, 0, 0, 0, 1, 1, 0), "rst_release");
    step(v(1, 32'hBFC00700, 0, 0, 0, 1, 1, 0), "post_a");
    step(v(0, 32'h0, 0, 1, 0, 1, 1, 0), "post_b");
    step(v(0, 32'h0, 0, 0, 0, 1, 1, 1), "post_c");
    step(v(0, 32'h0, 0, 0, 0, 1, 1, 0), "post_d");
    check("scoreboard drained", sb.size(), 32'h0);
    check("icache drained", icq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
